// File: rtl/ldm_stm_sequencer_pkg.sv
// ============================================================================
// Module : ldm_stm_sequencer_pkg
// Brief  : Shared types and constants for the LDM/STM block-transfer sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ldm_stm_sequencer_pkg;

    localparam int          c_word_w      = 32;
    localparam int          c_idx_w       = 4;
    localparam int          c_list_w      = 16;
    localparam logic [31:0] c_word_stride = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// ============================================================================
// Module : ldm_stm_sequencer_lowest_set_bit
// Brief  : 16-to-4 priority encoder selecting the lowest set bit, plus valid.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ldm_stm_sequencer_lowest_set_bit
    import ldm_stm_sequencer_pkg::*;
(
    input  logic [15:0] i_list,
    output logic [3:0]  o_idx,
    output logic        o_valid
);

    // Scan from the top down so the lowest set bit is the final winner.
    always_comb begin
        o_idx = 4'd0;
        for (int i = c_list_w - 1; i >= 0; i--) begin
            if (i_list[i]) begin
                o_idx = 4'(i);
            end
        end
    end

    assign o_valid = |i_list;

endmodule

`default_nettype wire

// File: rtl/ldm_stm_sequencer.sv
// ============================================================================
// Module : ldm_stm_sequencer
// Brief  : LDM/STM sequencer walking a register list one word per cycle.
//          Optional PC redirect for R15 loads under LDM_STM_PC_LOAD_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        LOAD,
    input  logic        PRE,
    input  logic        UP,
    input  logic [15:0] RLIST,
    input  logic [31:0] BASE,
    output logic [3:0]  RA,
    input  logic [31:0] RD,
    output logic [3:0]  WA,
    output logic [31:0] WD,
    output logic        WE,
    output logic [31:0] MADDR,
    output logic [31:0] MWD,
    output logic        MWE,
    input  logic [31:0] MRD,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] WB_ADDR
`ifdef LDM_STM_PC_LOAD_EN
    ,
    output logic        PC_LOAD,
    output logic [31:0] PC_VAL
`endif
);

    state_t      state_q, state_d;
    logic        load_q,  load_d;
    logic [15:0] list_q,  list_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wb_q,    wb_d;

    logic [4:0]  w_cnt;
    logic [31:0] w_span;
    logic [15:0] w_list_next;
    logic [3:0]  w_idx;
    logic        w_valid;
    logic        w_xfer;

    ldm_stm_sequencer_lowest_set_bit u_lsb (
        .i_list  (list_q),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_cnt       = popcount16(RLIST);
    assign w_span      = {25'd0, w_cnt, 2'b00};
    assign w_list_next = list_q & (list_q - 16'd1);

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        list_d  = list_q;
        addr_d  = addr_q;
        wb_d    = wb_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    load_d = LOAD;
                    list_d = RLIST;
                    wb_d   = UP ? (BASE + w_span) : (BASE - w_span);
                    // Lowest register always lands on the lowest address.
                    case ({UP, PRE})
                        2'b10:   addr_d = BASE;
                        2'b11:   addr_d = BASE + c_word_stride;
                        2'b00:   addr_d = BASE - w_span + c_word_stride;
                        default: addr_d = BASE - w_span;
                    endcase
                    state_d = (RLIST == 16'd0) ? ST_FINISH : ST_XFER;
                end
            end
            ST_XFER: begin
                list_d = w_list_next;
                addr_d = addr_q + c_word_stride;
                if (w_list_next == 16'd0) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            list_q  <= 16'd0;
            addr_q  <= 32'd0;
            wb_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            list_q  <= list_d;
            addr_q  <= addr_d;
            wb_q    <= wb_d;
        end
    end

    assign w_xfer  = (state_q == ST_XFER) && w_valid;

    assign RA      = w_idx;
    assign WA      = w_idx;
    assign MADDR   = addr_q;
    assign MWE     = w_xfer && !load_q;
    assign BUSY    = (state_q != ST_IDLE);
    assign DONE    = (state_q == ST_FINISH);
    assign WB_ADDR = wb_q;
    assign WD      = MRD;
    assign MWD     = RD;

`ifdef LDM_STM_PC_LOAD_EN
    logic w_pc_hit;
    assign w_pc_hit = w_xfer && load_q && (w_idx == 4'hF);
    assign WE       = w_xfer && load_q && !w_pc_hit;
    assign PC_LOAD  = w_pc_hit;
    assign PC_VAL   = MRD;
`else
    assign WE       = w_xfer && load_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
// ============================================================================
// Module : tb_ldm_stm_sequencer
// Brief  : Directed self-checking bench for ldm_stm_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ldm_stm_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, START, LOAD, PRE, UP;
    logic [15:0] RLIST;
    logic [31:0] BASE;
    logic [3:0]  RA, WA;
    logic [31:0] RD, WD, MADDR, MWD, MRD, WB_ADDR;
    logic        WE, MWE, BUSY, DONE;
`ifdef LDM_STM_PC_LOAD_EN
    logic        PC_LOAD;
    logic [31:0] PC_VAL;
`endif

    logic [31:0] rf  [16];
    logic [31:0] mem [256];
    logic        pl_mem, pl_rf;
    logic [7:0]  pl_addr;
    logic [3:0]  pl_ridx;
    logic [31:0] pl_data;

    int vectors    = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    ldm_stm_sequencer dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .LOAD    (LOAD),
        .PRE     (PRE),
        .UP      (UP),
        .RLIST   (RLIST),
        .BASE    (BASE),
        .RA      (RA),
        .RD      (RD),
        .WA      (WA),
        .WD      (WD),
        .WE      (WE),
        .MADDR   (MADDR),
        .MWD     (MWD),
        .MWE     (MWE),
        .MRD     (MRD),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .WB_ADDR (WB_ADDR)
`ifdef LDM_STM_PC_LOAD_EN
        ,
        .PC_LOAD (PC_LOAD),
        .PC_VAL  (PC_VAL)
`endif
    );

    assign RD  = rf[RA];
    assign MRD = mem[MADDR[9:2]];

    always @(posedge CLK) begin
        if (MWE)         mem[MADDR[9:2]] <= MWD;
        else if (pl_mem) mem[pl_addr]    <= pl_data;
    end

    always @(negedge CLK) begin
        if (WE)         rf[WA]      <= WD;
        else if (pl_rf) rf[pl_ridx] <= pl_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_mem(input logic [7:0] a, input logic [31:0] d);
        pl_mem = 1'b1; pl_addr = a; pl_data = d;
        @(posedge CLK); #1;
        pl_mem = 1'b0;
    endtask

    task automatic load_rf(input logic [3:0] r, input logic [31:0] d);
        pl_rf = 1'b1; pl_ridx = r; pl_data = d;
        @(negedge CLK); #1;
        pl_rf = 1'b0;
    endtask

    task automatic go(input logic ld, input logic pre, input logic up,
                      input logic [15:0] list, input logic [31:0] base);
        START = 1'b1; LOAD = ld; PRE = pre; UP = up; RLIST = list; BASE = base;
        tick();
        START = 1'b0; RLIST = 16'h0000; BASE = 32'h0;
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; LOAD = 1'b0; PRE = 1'b0; UP = 1'b0;
        RLIST = 16'h0; BASE = 32'h0;
        pl_mem = 1'b0; pl_rf = 1'b0; pl_addr = 8'h0; pl_ridx = 4'h0; pl_data = 32'h0;

        load_rf(4'd0, 32'h0000_00A0);
        load_rf(4'd2, 32'h0000_00A2);
        load_rf(4'd3, 32'h0000_00A3);
        for (int r = 4; r <= 15; r++) load_rf(4'(r), 32'h0);
        load_rf(4'd1, 32'h0);
        load_mem(8'h7E, 32'h1111_1111);
        load_mem(8'h7F, 32'h2222_2222);
        load_mem(8'h20, 32'h4444_4444);
        load_mem(8'h21, 32'h5555_5555);
        load_mem(8'h22, 32'h6666_6666);
        load_mem(8'h23, 32'h7777_7777);
        tick();

        check("rst_busy",  {31'd0, BUSY}, 32'd0);
        check("rst_done",  {31'd0, DONE}, 32'd0);
        check("rst_we",    {31'd0, WE},   32'd0);
        check("rst_mwe",   {31'd0, MWE},  32'd0);
        check("rst_ra",    {28'd0, RA},   32'd0);
        check("rst_wa",    {28'd0, WA},   32'd0);
        check("rst_maddr", MADDR,         32'd0);
        check("rst_wb",    WB_ADDR,       32'd0);
`ifdef LDM_STM_PC_LOAD_EN
        check("rst_pcld",  {31'd0, PC_LOAD}, 32'd0);
`endif
        RESET = 1'b0;
        tick();
        check("idle_busy", {31'd0, BUSY}, 32'd0);

        // STM IA of R0,R2,R3 from 0x100
        go(1'b0, 1'b0, 1'b1, 16'h000D, 32'h0000_0100);
        check("stm1_busy",  {31'd0, BUSY}, 32'd1);
        check("stm1_mwe",   {31'd0, MWE},  32'd1);
        check("stm1_we",    {31'd0, WE},   32'd0);
        check("stm1_ra",    {28'd0, RA},   32'd0);
        check("stm1_addr",  MADDR,         32'h100);
        check("stm1_mwd",   MWD,           32'hA0);
        tick();
        check("stm2_ra",    {28'd0, RA},   32'd2);
        check("stm2_addr",  MADDR,         32'h104);
        check("stm2_mwe",   {31'd0, MWE},  32'd1);
        tick();
        check("stm3_ra",    {28'd0, RA},   32'd3);
        check("stm3_addr",  MADDR,         32'h108);
        check("stm3_mwe",   {31'd0, MWE},  32'd1);
        tick();
        check("stm_done",   {31'd0, DONE}, 32'd1);
        check("stm_dbusy",  {31'd0, BUSY}, 32'd1);
        check("stm_dmwe",   {31'd0, MWE},  32'd0);
        check("stm_wb",     WB_ADDR,       32'h10C);
        tick();
        check("stm_idle",   {31'd0, BUSY}, 32'd0);
        check("stm_ndone",  {31'd0, DONE}, 32'd0);
        check("mem_100",    mem[8'h40],    32'hA0);
        check("mem_104",    mem[8'h41],    32'hA2);
        check("mem_108",    mem[8'h42],    32'hA3);

        // LDM DB of R1,R15 below 0x200
        go(1'b1, 1'b1, 1'b0, 16'h8002, 32'h0000_0200);
        check("ldm1_we",    {31'd0, WE},   32'd1);
        check("ldm1_wa",    {28'd0, WA},   32'd1);
        check("ldm1_addr",  MADDR,         32'h1F8);
        check("ldm1_wd",    WD,            32'h1111_1111);
        check("ldm1_mwe",   {31'd0, MWE},  32'd0);
        tick();
        check("ldm2_addr",  MADDR,         32'h1FC);
        check("ldm2_wa",    {28'd0, WA},   32'd15);
`ifdef LDM_STM_PC_LOAD_EN
        check("ldm2_we",    {31'd0, WE},      32'd0);
        check("ldm2_pcld",  {31'd0, PC_LOAD}, 32'd1);
        check("ldm2_pcval", PC_VAL,           32'h2222_2222);
`else
        check("ldm2_we",    {31'd0, WE},   32'd1);
        check("ldm2_wd",    WD,            32'h2222_2222);
`endif
        tick();
        check("ldm_done",   {31'd0, DONE}, 32'd1);
        check("ldm_wb",     WB_ADDR,       32'h1F8);
        check("ldm_dwe",    {31'd0, WE},   32'd0);
        tick();
        check("rf_r1",      rf[1],         32'h1111_1111);
`ifdef LDM_STM_PC_LOAD_EN
        check("rf_r15",     rf[15],        32'h0);
`else
        check("rf_r15",     rf[15],        32'h2222_2222);
`endif

        // Empty list, IB
        go(1'b0, 1'b1, 1'b1, 16'h0000, 32'h0000_0300);
        check("emp_done",   {31'd0, DONE}, 32'd1);
        check("emp_busy",   {31'd0, BUSY}, 32'd1);
        check("emp_we",     {31'd0, WE},   32'd0);
        check("emp_mwe",    {31'd0, MWE},  32'd0);
        check("emp_wb",     WB_ADDR,       32'h300);
        tick();
        check("emp_idle",   {31'd0, BUSY}, 32'd0);

        // Address wrap, STM IA of R0,R1 at 0xFFFFFFFC
        go(1'b0, 1'b0, 1'b1, 16'h0003, 32'hFFFF_FFFC);
        check("wrap1_addr", MADDR,         32'hFFFF_FFFC);
        check("wrap1_ra",   {28'd0, RA},   32'd0);
        tick();
        check("wrap2_addr", MADDR,         32'h0000_0000);
        check("wrap2_ra",   {28'd0, RA},   32'd1);
        tick();
        check("wrap_done",  {31'd0, DONE}, 32'd1);
        check("wrap_wb",    WB_ADDR,       32'h0000_0004);
        tick();
        check("wrap_m0",    mem[8'hFF],    32'hA0);
        check("wrap_m1",    mem[8'h00],    32'h1111_1111);

        // LDM IA of R4..R7 at 0x80, START re-asserted while busy, then reset
        go(1'b1, 1'b0, 1'b1, 16'h00F0, 32'h0000_0080);
        check("prot1_wa",   {28'd0, WA},   32'd4);
        check("prot1_we",   {31'd0, WE},   32'd1);
        START = 1'b1; LOAD = 1'b0; RLIST = 16'hFFFF; BASE = 32'h0000_0500;
        tick();
        START = 1'b0; RLIST = 16'h0; BASE = 32'h0;
        check("prot2_wa",   {28'd0, WA},   32'd5);
        check("prot2_we",   {31'd0, WE},   32'd1);
        check("prot2_mwe",  {31'd0, MWE},  32'd0);
        check("prot2_addr", MADDR,         32'h84);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst2_busy",  {31'd0, BUSY}, 32'd0);
        check("rst2_we",    {31'd0, WE},   32'd0);
        check("rst2_done",  {31'd0, DONE}, 32'd0);
        tick();
        check("rst3_done",  {31'd0, DONE}, 32'd0);
        check("rst3_we",    {31'd0, WE},   32'd0);
        check("rf_r4",      rf[4],         32'h4444_4444);
        check("rf_r5",      rf[5],         32'h5555_5555);
        check("rf_r6_pre",  rf[6],         32'h0);

        // Fresh transfer after the aborted one
        go(1'b1, 1'b0, 1'b1, 16'h0040, 32'h0000_0080);
        check("fresh_wa",   {28'd0, WA},   32'd6);
        check("fresh_we",   {31'd0, WE},   32'd1);
        tick();
        check("fresh_done", {31'd0, DONE}, 32'd1);
        check("fresh_wb",   WB_ADDR,       32'h84);
        tick();
        check("fresh_idle", {31'd0, BUSY}, 32'd0);
        check("rf_r6",      rf[6],         32'h4444_4444);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle block-transfer sequencer for the ARM-subset datapath. It drives the register file's ports for LDM/STM: it walks a 16-bit register list one register per cycle and moves words between data memory and the register file. For STM it reads registers and writes memory; for LDM it reads memory and writes registers. It sits beside the control unit, which stalls the PC while BUSY is high and uses WB_ADDR for base write-back.

## Interface
- No parameters; word width fixed at 32, register index width fixed at 4.
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin transfer; sampled only in IDLE.
- LOAD  in  1  1 = LDM, 0 = STM; sampled with START.
- PRE  in  1  1 = pre-index (IB/DB), 0 = post-index (IA/DA); sampled with START.
- UP  in  1  1 = increment, 0 = decrement; sampled with START.
- RLIST  in  16  register list, bit i = Ri; sampled with START.
- BASE  in  32  base address (value of Rn); sampled with START.
- RA  out  4  register-file read index (STM source).
- RD  in  32  register-file read data for RA.
- WA  out  4  register-file write index.
- WD  out  32  register-file write data; equals MRD.
- WE  out  1  register-file write enable.
- MADDR  out  32  data-memory word address.
- MWD  out  32  memory write data; equals RD.
- MWE  out  1  memory write enable.
- MRD  in  32  memory read data; combinational for MADDR.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle completion pulse.
- WB_ADDR  out  32  final base value for write-back; valid while DONE is high.
- PC_LOAD, PC_VAL  out  1, 32  present only with the macro (see Configuration).

## Operation
- States: IDLE, XFER, FINISH.
- IDLE with START=1:
  - Latch LOAD, the list, and N = popcount(RLIST).
  - Compute the start address and WB_ADDR.
  - Go to XFER, or to FINISH if RLIST = 0.
- Start address, all modulo 2^32:
  - IA: BASE.
  - IB: BASE+4.
  - DA: BASE−4N+4.
  - DB: BASE−4N.
- WB_ADDR = UP ? BASE+4N : BASE−4N, modulo 2^32.
- Transfer order:
  - Always ascending register index; the lowest set bit goes to the lowest address.
  - Each XFER cycle: current index = lowest set bit of the remaining list; MADDR = current address.
  - Posedge: clear that bit and add 4 to the address.
- XFER outputs:
  - STM: RA = current index, MWE = 1, WE = 0.
  - LDM: WA = current index, WE = 1, MWE = 0.
- Last bit cleared → FINISH. FINISH raises DONE for one cycle, then returns to IDLE.
- RA, WA, MADDR, WE, MWE and BUSY depend only on registered state. WD and MWD are combinational pass-throughs.
- Empty list: no transfers; DONE one cycle after START; WB_ADDR = BASE.
- START while BUSY is ignored. The inputs sampled with START are not re-read during the transfer.
- RESET during any state:
  - Next state is IDLE.
  - Enables deassert from the next cycle.
  - No DONE pulse.

## Timing
- Reset values: state IDLE; WE = MWE = BUSY = DONE = 0; RA = WA = 0; MADDR = 0; WB_ADDR = 0; PC_LOAD = 0.
- START sampled at edge k:
  - BUSY = 1 from cycle k+1 through cycle k+N+1 inclusive.
  - Transfers occur in cycles k+1 … k+N.
  - DONE = 1 in cycle k+N+1.
  - START is accepted again at edge k+N+2.
- Register writes: the register file captures on negedge CLK, so WA/WD/WE are stable half a cycle before capture.

## Configuration
- LDM_STM_PC_LOAD_EN defined:
  - An LDM that includes R15 does not assert WE for index 15.
  - Instead PC_LOAD = 1 and PC_VAL = MRD in that cycle, for the PC unit.
  - STM of R15 reads RA = 15; the register file returns the PC+8 value.
- Not defined:
  - PC_LOAD and PC_VAL ports are absent.
  - An R15 load drives WE with WA = 15 like any other register; the PC is not redirected.

## Structure
- Shared package holds:
  - State encoding: IDLE, FINISH and XFER.
  - Word-width and index-width constants.
  - The word-stride constant, 4.
- One sub-module, lowest_set_bit:
  - Combinational 16→4 priority encoder plus a valid flag.
  - Instantiated once on the remaining-list register.

## Test plan
- Reset, then STM: RLIST = 0x000D, BASE = 0x100, IA, with registers preloaded → MWE in 3 consecutive cycles writing R0, R2, R3 to 0x100, 0x104, 0x108; DONE in cycle 4; WB_ADDR = 0x10C.
- LDM: RLIST = 0x8002, BASE = 0x200, DB → reads 0x1F8 into R1, then 0x1FC into R15. With the macro: PC_LOAD = 1 with PC_VAL = mem[0x1FC] and no WE for index 15. Either build: WB_ADDR = 0x1F8.
- Empty list: RLIST = 0, IB → no WE/MWE; DONE at k+1; WB_ADDR = BASE.
- Wrap-around: BASE = 0xFFFFFFFC, IA, RLIST = 0x0003 → addresses 0xFFFFFFFC then 0x00000000; WB_ADDR = 0x00000004.
- Protocol: START re-asserted while BUSY is ignored. RESET asserted in the 2nd XFER cycle of a 4-register LDM → IDLE next cycle, no further WE, no DONE; a fresh START afterwards completes normally.
